fpu_issue_ctrl: RTL and testbench

- Sits between the execute stage and the single-precision FPU, which has a Start/Busy/Done handshake and multi-cycle latency.
- Captures one FP instruction from execute and stalls the pipeline while the FPU runs.
- Launches the FPU with a one-cycle start pulse, waits for done, then presents the registered result to writeback for exactly one cycle.
- Handles dynamic rounding-mode resolution, pipeline kill and an FPU timeout.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fpu_rm_resolve.sv | 20 ++
 rtl/fpu_issue_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants and types for the FP issue controller
package fpu_pkg;

    // Rounding-mode encodings as carried in the instruction rm field and fcsr.frm
    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam logic [2:0] DYN = 3'b111;

    // Quiet NaN returned when the FPU never answers
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [3:0] {
        OP_FADD  = 4'd0,
        OP_FSUB  = 4'd1,
        OP_FMUL  = 4'd2,
        OP_FDIV  = 4'd3,
        OP_FSQRT = 4'd4,
        OP_FMIN  = 4'd5,
        OP_FMAX  = 4'd6,
        OP_FMADD = 4'd7,
        OP_FMSUB = 4'd8,
        OP_FCVT  = 4'd9,
        OP_FCMP  = 4'd10,
        OP_FMV   = 4'd11
    } fpu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_WB     = 2'd3
    } issue_state_e;

endpackage

// File: rtl/fpu_rm_resolve.sv
// rtl/fpu_rm_resolve.sv - resolves DYN rounding mode and flags reserved encodings
module fpu_rm_resolve
    import fpu_pkg::*;
(
    input  logic [2:0] i_ex_rm,
    input  logic [2:0] i_csr_frm,
    output logic [2:0] o_rm,
    output logic       o_illegal
);

    logic [2:0] w_rm;

    // DYN defers to fcsr.frm; anything above RMM after resolution is reserved
    always_comb begin
        w_rm      = (i_ex_rm == DYN) ? i_csr_frm : i_ex_rm;
        o_rm      = w_rm;
        o_illegal = (w_rm > RMM);
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - issues one FP instruction to a start/busy/done FPU and writes back its result
module fpu_issue_ctrl #(
    parameter int          TIMEOUT   = 64,
    parameter int          CNT_W     = 7,
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_fp_valid,
    input  logic [3:0]  ex_fp_op,
    input  logic [2:0]  ex_rm,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [31:0] ex_rs3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_fp_we,
    input  logic [2:0]  csr_frm,
    input  logic        kill,
    output logic        fpu_start,
    output logic [3:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [31:0] fpu_c,
    output logic        fpu_we,
    input  logic        fpu_busy,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_fp_we,
    output logic        exc_illegal_rm,
    output logic        exc_timeout
);

    // Last WAIT cycle on which a missing done is still tolerated
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fpu_pkg::issue_state_e r_state;
    fpu_pkg::issue_state_e w_state_nxt;

    logic [2:0]       w_rm;
    logic             w_rm_illegal;
    logic             w_accept;
    logic             w_launch;
    logic             w_timeout_hit;

    logic [3:0]       r_op;
    logic [2:0]       r_rm;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_c;
    logic [4:0]       r_rd;
    logic             r_fp_we;
    logic [31:0]      r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_killed;
    logic             r_timed_out;

    fpu_rm_resolve u_rm_resolve (
        .i_ex_rm   (ex_rm),
        .i_csr_frm (csr_frm),
        .o_rm      (w_rm),
        .o_illegal (w_rm_illegal)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= fpu_pkg::S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the combinational handshake/strobe outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_launch       = 1'b0;
        w_timeout_hit  = 1'b0;
        fpu_start      = 1'b0;
        stall          = 1'b0;
        wb_valid       = 1'b0;
        exc_illegal_rm = 1'b0;
        exc_timeout    = 1'b0;
        case (r_state)
            fpu_pkg::S_IDLE: begin
                if (ex_fp_valid && !kill) begin
                    if (w_rm_illegal) begin
                        exc_illegal_rm = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        stall       = 1'b1;
                        w_state_nxt = fpu_pkg::S_LAUNCH;
                    end
                end
            end
            fpu_pkg::S_LAUNCH: begin
                stall = 1'b1;
                // An FPU still draining a previous op must go idle before we start it again
                if (!fpu_busy) begin
                    fpu_start   = 1'b1;
                    w_launch    = 1'b1;
                    w_state_nxt = fpu_pkg::S_WAIT;
                end
            end
            fpu_pkg::S_WAIT: begin
                stall = 1'b1;
                if (fpu_done) begin
                    w_state_nxt = fpu_pkg::S_WB;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = fpu_pkg::S_WB;
                end
            end
            fpu_pkg::S_WB: begin
                wb_valid    = !r_killed;
                exc_timeout = r_timed_out;
                w_state_nxt = fpu_pkg::S_IDLE;
            end
            default: begin
                w_state_nxt = fpu_pkg::S_IDLE;
            end
        endcase
    end

    // Instruction latches, loaded only on acceptance so the FPU inputs stay stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_rm    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_rd    <= '0;
            r_fp_we <= 1'b0;
        end else if (w_accept) begin
            r_op    <= ex_fp_op;
            r_rm    <= w_rm;
            r_a     <= ex_rs1;
            r_b     <= ex_rs2;
            r_c     <= ex_rs3;
            r_rd    <= ex_rd;
            r_fp_we <= ex_fp_we;
        end
    end

    // WAIT-cycle counter, restarted on the start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_launch) begin
            r_cnt <= '0;
        end else if (r_state == fpu_pkg::S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result register: FPU answer on done, canonical NaN when the FPU hangs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if ((r_state == fpu_pkg::S_WAIT) && fpu_done) begin
            r_result <= fpu_result;
        end else if (w_timeout_hit) begin
            r_result <= CANON_NAN;
        end
    end

    // Kill and timeout flags, both cleared as WB hands back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_killed    <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (r_state == fpu_pkg::S_WB) begin
            r_killed    <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            if (kill && ((r_state == fpu_pkg::S_LAUNCH) || (r_state == fpu_pkg::S_WAIT))) begin
                r_killed <= 1'b1;
            end
            if (w_timeout_hit) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign fpu_op   = r_op;
    assign fpu_rm   = r_rm;
    assign fpu_a    = r_a;
    assign fpu_b    = r_b;
    assign fpu_c    = r_c;
    assign fpu_we   = r_fp_we;
    assign wb_rd    = r_rd;
    assign wb_data  = r_result;
    assign wb_fp_we = r_fp_we;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - self-checking bench for fpu_issue_ctrl
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int          TIMEOUT = 64;
    localparam logic [31:0] NAN     = 32'h7FC0_0000;

    logic        clk;
    logic        rst_n;
    logic        ex_fp_valid;
    logic [3:0]  ex_fp_op;
    logic [2:0]  ex_rm;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_rs3;
    logic [4:0]  ex_rd;
    logic        ex_fp_we;
    logic [2:0]  csr_frm;
    logic        kill;
    logic        fpu_start;
    logic [3:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_c;
    logic        fpu_we;
    logic        fpu_busy;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_fp_we;
    logic        exc_illegal_rm;
    logic        exc_timeout;

    fpu_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7), .CANON_NAN(NAN)) dut (
        .clk(clk), .rst_n(rst_n), .ex_fp_valid(ex_fp_valid), .ex_fp_op(ex_fp_op),
        .ex_rm(ex_rm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs3(ex_rs3),
        .ex_rd(ex_rd), .ex_fp_we(ex_fp_we), .csr_frm(csr_frm), .kill(kill),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a),
        .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_we(fpu_we), .fpu_busy(fpu_busy),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fp_we(wb_fp_we),
        .exc_illegal_rm(exc_illegal_rm), .exc_timeout(exc_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected writebacks
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fp_we;
        int          cyc;
    } wb_t;
    wb_t sb[$];
    int  cyc = 0;

    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (wb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wb", 32'(wb_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                    chk("wb_fp_we", 32'(wb_fp_we), 32'(e.fp_we));
                    chk("wb_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // FPU model: done arrives model_lat cycles after the start cycle
    int          model_lat = 1;
    logic        model_hang = 1'b0;
    logic [31:0] model_res = '0;
    logic        stray_req = 1'b0;
    int          model_cnt = 0;
    logic [31:0] model_q = '0;

    initial begin
        fpu_done   = 1'b0;
        fpu_result = '0;
        forever begin
            @(negedge clk);
            fpu_done = 1'b0;
            if (!rst_n) begin
                model_cnt = 0;
            end else if (fpu_start) begin
                model_cnt = model_lat;
                model_q   = model_res;
            end else if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0 && !model_hang) begin
                    fpu_done   = 1'b1;
                    fpu_result = model_q;
                end
            end else if (stray_req) begin
                fpu_done   = 1'b1;
                fpu_result = 32'hDEAD_BEEF;
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rm;
        logic [2:0]  frm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] res;
        int          lat;
        int          kill_at;
        int          busy;
        logic        hang;
        logic [2:0]  exp_rm;
        logic        exp_ill;
    } vec_t;
    vec_t vt[12];

    task automatic run_vec(input vec_t v);
        bit rejected = v.exp_ill || (v.kill_at == 0);
        int start_j  = 1 + v.busy;
        int wb_j     = v.hang ? (start_j + 1 + TIMEOUT) : (start_j + v.lat + 1);
        int n_start  = 0;
        bit done_loop = 1'b0;
        model_lat   = v.lat;
        model_res   = v.res;
        model_hang  = v.hang;
        ex_fp_op    = v.op;
        ex_rm       = v.rm;
        csr_frm     = v.frm;
        ex_rs1      = v.a;
        ex_rs2      = v.b;
        ex_rs3      = v.c;
        ex_rd       = v.rd;
        ex_fp_we    = v.we;
        ex_fp_valid = 1'b1;
        kill        = (v.kill_at == 0);
        if (!rejected && v.kill_at < 0)
            sb.push_back('{rd: v.rd, data: (v.hang ? NAN : v.res), fp_we: v.we, cyc: cyc + 1 + wb_j});
        @(negedge clk);
        chk("c0_stall", 32'(stall), 32'(!rejected));
        chk("c0_illegal_rm", 32'(exc_illegal_rm), 32'(v.exp_ill));
        chk("c0_start", 32'(fpu_start), 32'd0);
        for (int j = 1; j <= wb_j + 4 && !done_loop; j++) begin
            @(posedge clk); #1;
            ex_fp_valid = 1'b0;
            kill        = (j == v.kill_at);
            fpu_busy    = (j <= v.busy);
            @(negedge clk);
            if (fpu_start === 1'b1) begin
                n_start++;
                chk("start_cycle", j, start_j);
                chk("fpu_rm", 32'(fpu_rm), 32'(v.exp_rm));
                chk("fpu_op", 32'(fpu_op), 32'(v.op));
                chk("fpu_b", fpu_b, v.b);
                chk("fpu_c", fpu_c, v.c);
                chk("fpu_we", 32'(fpu_we), 32'(v.we));
            end
            if (rejected) begin
                chk("rej_stall", 32'(stall), 32'd0);
                if (j == 3) done_loop = 1'b1;
            end else if (stall !== 1'b1) begin
                chk("wb_at_cycle", j, wb_j);
                chk("wb_valid", 32'(wb_valid), 32'(v.kill_at < 0));
                chk("exc_timeout", 32'(exc_timeout), 32'(v.hang));
                done_loop = 1'b1;
            end else begin
                chk("fpu_a_stable", fpu_a, v.a);
            end
        end
        chk("start_count", n_start, rejected ? 0 : 1);
        chk("sequence_ended", 32'(done_loop), 32'd1);
        fpu_busy = 1'b0;
        kill     = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //        op        rm      frm     a             b             c             rd     we    res           lat kill busy hang exp_rm  ill
        vt[0]  = '{OP_FADD,  RNE,    RNE,    32'h3F800000, 32'h40000000, 32'h00000000, 5'd5,  1'b1, 32'h40400000, 9,  -1,  0,   1'b0, RNE,    1'b0};
        vt[1]  = '{OP_FMUL,  DYN,    RTZ,    32'h40000000, 32'h40400000, 32'h00000000, 5'd7,  1'b1, 32'h40C00000, 4,  -1,  0,   1'b0, RTZ,    1'b0};
        vt[2]  = '{OP_FDIV,  RMM,    RNE,    32'h41200000, 32'h40000000, 32'h00000000, 5'd31, 1'b0, 32'h12345678, 12, -1,  0,   1'b0, RMM,    1'b0};
        vt[3]  = '{OP_FADD,  DYN,    3'b110, 32'h11111111, 32'h22222222, 32'h00000000, 5'd1,  1'b1, 32'h0,        3,  -1,  0,   1'b0, 3'b110, 1'b1};
        vt[4]  = '{OP_FSUB,  3'b101, RNE,    32'h33333333, 32'h44444444, 32'h00000000, 5'd2,  1'b1, 32'h0,        3,  -1,  0,   1'b0, 3'b101, 1'b1};
        vt[5]  = '{OP_FMUL,  DYN,    3'b111, 32'h55555555, 32'h66666666, 32'h00000000, 5'd2,  1'b1, 32'h0,        3,  -1,  0,   1'b0, 3'b111, 1'b1};
        vt[6]  = '{OP_FADD,  RNE,    RNE,    32'h77777777, 32'h88888888, 32'h00000000, 5'd6,  1'b1, 32'h0,        3,  0,   0,   1'b0, RNE,    1'b0};
        vt[7]  = '{OP_FMADD, RDN,    RNE,    32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 5'd3,  1'b1, 32'hCAFEF00D, 9,  4,   0,   1'b0, RDN,    1'b0};
        vt[8]  = '{OP_FSUB,  DYN,    RUP,    32'h40800000, 32'h3F800000, 32'h00000000, 5'd4,  1'b1, 32'h40400000, 1,  -1,  0,   1'b0, RUP,    1'b0};
        vt[9]  = '{OP_FSQRT, RTZ,    RNE,    32'h41800000, 32'h00000000, 32'h00000000, 5'd12, 1'b1, 32'h40800000, 5,  -1,  3,   1'b0, RTZ,    1'b0};
        vt[10] = '{OP_FDIV,  RNE,    RNE,    32'h3F800000, 32'h00000000, 32'h00000000, 5'd9,  1'b1, 32'h0BADF00D, 5,  -1,  0,   1'b1, RNE,    1'b0};
        vt[11] = '{OP_FADD,  RUP,    RNE,    32'hBF800000, 32'h3F800000, 32'h00000000, 5'd0,  1'b0, 32'h00000000, 2,  -1,  0,   1'b0, RUP,    1'b0};

        rst_n = 1'b0; ex_fp_valid = 1'b0; ex_fp_op = '0; ex_rm = '0; csr_frm = '0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rs3 = '0; ex_rd = '0; ex_fp_we = 1'b0;
        kill = 1'b0; fpu_busy = 1'b0;
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_start", 32'(fpu_start), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) run_vec(vt[i]);

        // Stray done while idle must not produce a writeback
        stray_req = 1'b1;
        @(posedge clk); #1;
        stray_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_stall", 32'(stall), 32'd0);
            chk("stray_wb_valid", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_vec(vt[0]);

        // Asynchronous reset in the middle of WAIT
        model_lat = 9; model_hang = 1'b0; model_res = 32'h13572468;
        ex_fp_op = OP_FMUL; ex_rm = RNE; ex_rs1 = 32'hFEEDFACE; ex_rs2 = 32'h1; ex_rd = 5'd17;
        ex_fp_we = 1'b1; ex_fp_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            ex_fp_valid = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        chk("arst_wb_rd", 32'(wb_rd), 32'd0);
        chk("arst_fpu_a", fpu_a, 32'd0);
        chk("arst_fpu_we", 32'(fpu_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(stall), 32'd0);
            chk("post_rst_no_wb", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_vec(vt[1]);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
